// File: rtl/keypad_scan_debounce_if.sv
// Keypad scanner bundle: column drive and row sense toward the matrix, debounced key code toward the decoder.
interface keypad_scan_debounce_if;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] onehot;
    logic        key_valid;
    logic        key_pulse;

    modport master (
        input  row_n,
        output col_n,
        output onehot,
        output key_valid,
        output key_pulse
    );

    modport slave (
        output row_n,
        input  col_n,
        input  onehot,
        input  key_valid,
        input  key_pulse
    );
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x4 active-low keypad scanner with sweep-level debounce and multi-key rollover suppression.
//  state | meaning
//  COL0  | column 0 driven low
//  COL1  | column 1 driven low
//  COL2  | column 2 driven low
//  COL3  | column 3 driven low, tick here ends a sweep
module keypad_scan_debounce #(
    parameter int SCAN_DIV       = 50_000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                   clk,
    input  logic                   RSTn,
    keypad_scan_debounce_if.master kp
);
    localparam int               CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [3:0]       DEB     = 4'(DEBOUNCE_SCANS);

    localparam logic [1:0] COL0 = 2'd0;
    localparam logic [1:0] COL1 = 2'd1;
    localparam logic [1:0] COL2 = 2'd2;
    localparam logic [1:0] COL3 = 2'd3;

    logic [3:0]       r_row_s1, r_row_s2;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_col;
    logic [15:0]      r_image, r_sweep, r_prev, r_onehot;
    logic [3:0]       r_stable;
    logic             r_done, r_valid, r_pulse;

    logic             w_tick;
    logic [1:0]       w_col_next;
    logic [15:0]      w_image_next;
    logic             w_multi;
    logic [15:0]      w_img;
    logic             w_same;
    logic [3:0]       w_stable_next;
    logic             w_commit;

    assign w_tick = (r_cnt == CNT_MAX);

    always_comb begin
        w_col_next = r_col;
        case (r_col)
            COL0:    w_col_next = COL1;
            COL1:    w_col_next = COL2;
            COL2:    w_col_next = COL3;
            COL3:    w_col_next = COL0;
            default: w_col_next = COL0;
        endcase
    end

    always_comb begin
        w_image_next = r_image;
        for (int r = 0; r < 4; r++) begin
            w_image_next[r*4 + int'(r_col)] = ~r_row_s2[r];
        end
    end

    // More than one key down: hold the committed code instead of the ambiguous image.
    assign w_multi       = (r_sweep & (r_sweep - 16'd1)) != 16'd0;
    assign w_img         = w_multi ? r_onehot : r_sweep;
    assign w_same        = (w_img == r_prev);
    assign w_stable_next = !w_same ? 4'd1 :
                           (r_stable >= DEB) ? DEB : r_stable + 4'd1;
    assign w_commit      = r_done && (w_stable_next == DEB) && (w_img != r_onehot);

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_row_s1 <= 4'hF;
            r_row_s2 <= 4'hF;
            r_cnt    <= '0;
            r_col    <= COL0;
            r_image  <= '0;
            r_sweep  <= '0;
            r_done   <= 1'b0;
            r_prev   <= '0;
            r_stable <= '0;
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_pulse  <= 1'b0;
        end else begin
            r_row_s1 <= kp.row_n;
            r_row_s2 <= r_row_s1;
            r_cnt    <= w_tick ? '0 : r_cnt + 1'b1;
            r_done   <= w_tick && (r_col == COL3);
            if (w_tick) begin
                r_col <= w_col_next;
                // Last column hands the full image off and clears for the next sweep.
                if (r_col == COL3) begin
                    r_sweep <= w_image_next;
                    r_image <= '0;
                end else begin
                    r_image <= w_image_next;
                end
            end
            if (r_done) begin
                r_stable <= w_stable_next;
                if (!w_same) begin
                    r_prev <= w_img;
                end
            end
            if (w_commit) begin
                r_onehot <= w_img;
                r_valid  <= |w_img;
            end
            r_pulse <= w_commit && (|w_img);
        end
    end

    assign kp.col_n     = ~(4'b0001 << r_col);
    assign kp.onehot    = r_onehot;
    assign kp.key_valid = r_valid;
    assign kp.key_pulse = r_pulse;
endmodule
